sram_bank_ctrl: RTL and testbench

SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

---
 rtl/sram_bank_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_sram_bank_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_ctrl.sv
// -----------------------------------------------------------------------------
// sram_bank_ctrl
//
// Single-bank SRAM controller with a valid/ready request port. A request is
// latched on the accept edge (IDLE and mem_s_valid). Writes merge the enabled
// byte lanes into the addressed word; reads return the word after RD_LATENCY
// cycles. The completion strobe mem_s_ready is high for exactly one cycle.
//
// Optional feature (compile-time macro SRAM_BOUNDS_CHECK_EN):
//   defined   : a word index >= DEPTH_WORDS is flagged with mem_s_err on the
//               response, the array is not written and read data is zero.
//   undefined : the word index wraps to log2(DEPTH_WORDS) bits and
//               mem_s_err is tied low.
//
// Parameters
//   DATA_WIDTH  : bus width in bits, multiple of 8 (NB = DATA_WIDTH/8 lanes)
//   DEPTH_WORDS : words in the bank, power of two, 16..65536
//   RD_LATENCY  : accept-to-read-response cycles, 1..4
//   INIT_ZERO   : 1 = array zero at time 0, 0 = contents undefined
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   mem_s_valid  in   request valid, held until mem_s_ready
//   mem_s_ready  out  one-cycle completion strobe
//   mem_s_addr   in   byte address (word index = addr >> log2(NB))
//   mem_s_wdata  in   write data
//   mem_s_wstrb  in   byte write enables, all zero = read
//   mem_s_rdata  out  read data, zero whenever mem_s_ready is low
//   mem_s_err    out  error flag, only meaningful with mem_s_ready
//   busy         out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module sram_bank_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned INIT_ZERO   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_s_valid,
  output logic                    mem_s_ready,
  input  logic [31:0]             mem_s_addr,
  input  logic [DATA_WIDTH-1:0]   mem_s_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_s_wstrb,
  output logic [DATA_WIDTH-1:0]   mem_s_rdata,
  output logic                    mem_s_err,
  output logic                    busy
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned BW = $clog2(NB);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LOAD = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    accept;
  logic                    wr_q;
  logic                    oob_q;
  logic                    oob_in;
  logic [AW-1:0]           idx_in;
  logic [AW-1:0]           idx_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NB-1:0]           wstrb_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    mem_we;
  logic                    mem_re;
  logic                    unused_addr_bits;

  // Byte-offset bits never select anything; upper bits only matter when
  // bounds checking is compiled in.
  assign unused_addr_bits = ^mem_s_addr;

  assign idx_in = mem_s_addr[BW +: AW];

`ifdef SRAM_BOUNDS_CHECK_EN
  assign oob_in = |mem_s_addr[31:AW+BW];
`else
  assign oob_in = 1'b0;
`endif

  assign accept = (state_q == IDLE) && mem_s_valid;

  // ---------------------------------------------------------------------------
  // Control state (asynchronous reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q  <= |mem_s_wstrb;
        oob_q <= oob_in;
      end
    end
  end

  // Request payload: only sampled at accept, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q   <= idx_in;
      wdata_q <= mem_s_wdata;
      wstrb_q <= mem_s_wstrb;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_s_valid) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q || (RD_LATENCY <= 1)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        // Leave as the counter reaches zero so RESP lands RD_LATENCY cycles
        // after the accept edge.
        if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Array access
  // ---------------------------------------------------------------------------
  // The write is qualified by reset so a reset coinciding with ACCESS cannot
  // commit a partial transaction.
  assign mem_we = reset && (state_q == ACCESS) && wr_q && !oob_q;
  assign mem_re = (state_q == ACCESS) && !wr_q;

  if (INIT_ZERO != 0) begin : g_mem_zero
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clk) begin
      if (mem_we) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (wstrb_q[i]) begin
            mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
          end
        end
      end
      if (mem_re) begin
        rd_q <= mem[idx_q];
      end
    end
  end else begin : g_mem_raw
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (mem_we) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (wstrb_q[i]) begin
            mem[idx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
          end
        end
      end
      if (mem_re) begin
        rd_q <= mem[idx_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state, so reset clears them at once)
  // ---------------------------------------------------------------------------
  assign busy        = (state_q != IDLE);
  assign mem_s_ready = (state_q == RESP);
  assign mem_s_rdata = (mem_s_ready && !wr_q && !oob_q) ? rd_q : '0;

`ifdef SRAM_BOUNDS_CHECK_EN
  assign mem_s_err = mem_s_ready && oob_q;
`else
  assign mem_s_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_bank_ctrl
//
// Two instances: dut0 (defaults, RD_LATENCY=1, 2048 words) and dut1
// (RD_LATENCY=3, 16 words). Drivers push the expected response (data, error
// flag, ready cycle) into a per-instance queue at the accept edge; a monitor
// on the falling edge pops and compares whenever mem_s_ready is seen.
// -----------------------------------------------------------------------------
module tb_sram_bank_ctrl;

`ifdef SRAM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        is_rd;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        vld  [2];
  logic        rdy  [2];
  logic [31:0] adr  [2];
  logic [31:0] wd   [2];
  logic [3:0]  ws   [2];
  logic [31:0] rdt  [2];
  logic        err  [2];
  logic        bsy  [2];

  int          cyc;
  int          resp_cyc [2];
  int          n_checks;
  int          n_fail;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mdl [2048];

  sram_bank_ctrl #(
    .DATA_WIDTH (32),
    .DEPTH_WORDS(2048),
    .RD_LATENCY (1),
    .INIT_ZERO  (1)
  ) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .mem_s_valid(vld[0]),
    .mem_s_ready(rdy[0]),
    .mem_s_addr (adr[0]),
    .mem_s_wdata(wd[0]),
    .mem_s_wstrb(ws[0]),
    .mem_s_rdata(rdt[0]),
    .mem_s_err  (err[0]),
    .busy       (bsy[0])
  );

  sram_bank_ctrl #(
    .DATA_WIDTH (32),
    .DEPTH_WORDS(16),
    .RD_LATENCY (3),
    .INIT_ZERO  (1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .mem_s_valid(vld[1]),
    .mem_s_ready(rdy[1]),
    .mem_s_addr (adr[1]),
    .mem_s_wdata(wd[1]),
    .mem_s_wstrb(ws[1]),
    .mem_s_rdata(rdt[1]),
    .mem_s_err  (err[1]),
    .busy       (bsy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int d,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cycle %0d: got 0x%08h, expected 0x%08h",
               name, d, cyc, act, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic mon(input int d);
    exp_t e;
    logic got;
    if (rdy[d]) begin
      got = 1'b0;
      if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      if (!got) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready dut%0d @cycle %0d: got ready=1, expected no response",
                 d, cyc);
      end else begin
        chk("ready_cycle", d, cyc, e.cyc);
        chk("resp_err", d, err[d], e.err);
        if (e.is_rd) chk("resp_rdata", d, rdt[d], e.rdata);
      end
    end else begin
      chk("rdata_idle_zero", d, rdt[d], 32'h0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------------------------------------------------------------------
  // Driver: called at a falling edge. Pushes the expectation on the accept
  // edge, scrambles inputs while busy, returns at the ready falling edge.
  // ---------------------------------------------------------------------------
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, input logic [31:0] er,
                       input logic ee, input int lat);
    exp_t e;
    logic got;
    vld[d] = 1'b1;
    adr[d] = a;
    wd[d]  = w;
    ws[d]  = s;
    if (cyc == resp_cyc[d]) @(posedge clk);  // RESP -> IDLE edge
    @(posedge clk);                           // accept edge
    #1;
    e.rdata = er;
    e.err   = ee;
    e.is_rd = (s == 4'h0);
    e.cyc   = cyc + lat;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    adr[d] = ~a;
    wd[d]  = ~w;
    ws[d]  = ~s;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      chk("busy_in_flight", d, bsy[d], 1'b1);
      got = rdy[d];
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout dut%0d @cycle %0d: got no ready in 10 cycles, expected ready at %0d",
               d, cyc, e.cyc);
    end
    vld[d]      = 1'b0;
    resp_cyc[d] = cyc;
  endtask

  function automatic logic oob0(input logic [31:0] a);
    return BCHK && (a[31:13] != 19'h0);
  endfunction

  task automatic wr_a(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    logic [10:0] idx;
    idx = a[12:2];
    if (!oob0(a)) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) mdl[idx][i*8 +: 8] = w[i*8 +: 8];
      end
    end
    issue(0, a, w, s, 32'h0, oob0(a), 1);
  endtask

  task automatic rd_a(input logic [31:0] a, input logic [31:0] er, input logic ee);
    issue(0, a, 32'h0, 4'h0, er, ee, 1);
  endtask

  task automatic chk_quiet(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_ready"}, d, rdy[d], 1'b0);
      chk({tag, "_rdata"}, d, rdt[d], 32'h0);
      chk({tag, "_err"},   d, err[d], 1'b0);
      chk({tag, "_busy"},  d, bsy[d], 1'b0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
    clk = 1'b0;
    reset = 1'b1;
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; adr[d] = '0; wd[d] = '0; ws[d] = '0; resp_cyc[d] = -10;
    end
    for (int i = 0; i < 2048; i++) mdl[i] = 32'h0;

    #2 reset = 1'b0;
    #1 chk_quiet("reset_async");
    @(negedge clk);
    @(negedge clk);
    chk_quiet("reset_hold");
    reset = 1'b1;

    // First accept on the first rising edge after release; array starts zero.
    rd_a(32'h10, 32'h0, 1'b0);
    wr_a(32'h10, 32'h11223344, 4'hF);
    rd_a(32'h10, 32'h11223344, 1'b0);
    wr_a(32'h10, 32'hAABBCCDD, 4'h5);
    rd_a(32'h10, 32'h11BB33DD, 1'b0);
    rd_a(32'h13, 32'h11BB33DD, 1'b0);
    wr_a(32'h14, 32'h01020304, 4'h8);
    rd_a(32'h14, 32'h01000000, 1'b0);

    // Address beyond the bank: error with bounds check, wrap to word 0 without.
    wr_a(32'h2000, 32'hCAFEF00D, 4'hF);
    rd_a(32'h0, BCHK ? 32'h0 : 32'hCAFEF00D, 1'b0);
    rd_a(32'h2000, BCHK ? 32'h0 : 32'hCAFEF00D, BCHK);

    // Reset while a write sits in ACCESS: array untouched, no response.
    @(negedge clk);
    vld[0] = 1'b1; adr[0] = 32'h40; wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1 chk_quiet("abort_write");
    @(negedge clk);
    reset = 1'b1;
    rd_a(32'h40, 32'h0, 1'b0);

    // RD_LATENCY=3 instance.
    issue(1, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0, 3);
    issue(1, 32'h20, 32'h5A5A1234, 4'hF, 32'h0, 1'b0, 1);
    issue(1, 32'h20, 32'h0, 4'h0, 32'h5A5A1234, 1'b0, 3);

    // Reset during WAIT of a read: aborted, then next request on first edge.
    @(negedge clk);
    vld[1] = 1'b1; adr[1] = 32'h20; wd[1] = 32'h0; ws[1] = 4'h0;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_quiet("abort_wait");
    vld[1] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    issue(1, 32'h20, 32'h0, 4'h0, 32'h5A5A1234, 1'b0, 3);

    // Back-to-back random traffic against the reference model.
    for (int k = 0; k < 100; k++) begin
      a = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      w = $urandom;
      s = 4'($urandom_range(0, 15));
      if (s == 4'h0) rd_a(a, mdl[a[12:2]], 1'b0);
      else           wr_a(a, w, s);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("outstanding_q0", 0, q0.size(), 0);
    chk("outstanding_q1", 1, q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
